reg_port_arbiter: RTL and testbench

REG_PORT_ARBITER -- requirements
Module: reg_port_arbiter

---
 rtl/reg_port_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_reg_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_port_arbiter.sv
// ============================================================================
// Module  : reg_port_arbiter
// Brief   : Two-port (CPU / debug) arbiter in front of a single-port register
//           file, with a RUN -> DRAIN -> HALTED debug halt handshake.
//           Optional starvation guard for the debug port is enabled by
//           defining the macro STARVE_GUARD_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module reg_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  // CPU port
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [3:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_gnt,
  output logic       cpu_rvalid,
  output logic [7:0] cpu_rdata,
  // Debug port
  input  logic       dbg_req,
  input  logic       dbg_we,
  input  logic [3:0] dbg_addr,
  input  logic [7:0] dbg_wdata,
  output logic       dbg_gnt,
  output logic       dbg_rvalid,
  output logic [7:0] dbg_rdata,
  // Halt handshake
  input  logic       dbg_halt_req,
  input  logic       cpu_idle,
  output logic       cpu_stall,
  output logic       dbg_halted,
  // Register file side
  output logic       rf_en,
  output logic       rf_we,
  output logic [3:0] rf_addr,
  output logic [7:0] rf_wdata,
  input  logic [7:0] rf_rdata
);

  // Addresses above sp (8) are reserved and never reach the register file.
  localparam logic [3:0] C_LAST_ADDR = 4'd8;

  // Elaboration-time range check on the starvation limit.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("reg_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_cpu_stall;
  logic       r_dbg_halted;
  logic       r_cpu_pend;
  logic       r_cpu_rsv;
  logic       r_dbg_pend;
  logic       r_dbg_rsv;

  logic       w_halted_st;
  logic       w_force_dbg;
  logic       w_cpu_gnt;
  logic       w_dbg_gnt;
  logic       w_any_gnt;
  logic       w_sel_we;
  logic [3:0] w_sel_addr;
  logic [7:0] w_sel_wdata;
  logic       w_sel_rsv;
  logic       w_rf_en;
  logic       w_cpu_rd;
  logic       w_dbg_rd;

  assign w_halted_st = (r_state == S_HALTED);

`ifdef STARVE_GUARD_EN
  logic [3:0] r_starve_cnt;

  // Debug steals the port once it has been denied STARVE_LIMIT cycles in a row.
  assign w_force_dbg = !w_halted_st && dbg_req &&
                       (r_starve_cnt == STARVE_LIMIT[3:0]);

  // Count consecutive denied debug cycles, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 4'd0;
    end else if (w_dbg_gnt || !dbg_req) begin
      r_starve_cnt <= 4'd0;
    end else if (r_starve_cnt != STARVE_LIMIT[3:0]) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end
`else
  assign w_force_dbg = 1'b0;
`endif

  // Grants are combinational; reset masks them so every output is quiet.
  assign w_dbg_gnt = rst_n && dbg_req && (w_halted_st || w_force_dbg || !cpu_req);
  assign w_cpu_gnt = rst_n && cpu_req && !w_halted_st && !w_force_dbg;
  assign w_any_gnt = w_cpu_gnt || w_dbg_gnt;

  // Command mux from whichever side won.
  assign w_sel_we    = w_dbg_gnt ? dbg_we    : cpu_we;
  assign w_sel_addr  = w_dbg_gnt ? dbg_addr  : cpu_addr;
  assign w_sel_wdata = w_dbg_gnt ? dbg_wdata : cpu_wdata;
  assign w_sel_rsv   = (w_sel_addr > C_LAST_ADDR);

  // Reserved accesses are granted but never strobe the register file; the
  // whole rf bus is zeroed whenever no strobe is issued.
  assign w_rf_en  = w_any_gnt && !w_sel_rsv;
  assign rf_en    = w_rf_en;
  assign rf_we    = w_rf_en && w_sel_we;
  assign rf_addr  = w_rf_en ? w_sel_addr  : 4'h0;
  assign rf_wdata = w_rf_en ? w_sel_wdata : 8'h00;

  assign cpu_gnt = w_cpu_gnt;
  assign dbg_gnt = w_dbg_gnt;

  assign w_cpu_rd = w_cpu_gnt && !cpu_we;
  assign w_dbg_rd = w_dbg_gnt && !dbg_we;

  // Remember which side owes a read response next cycle and whether it was reserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_pend <= 1'b0;
      r_cpu_rsv  <= 1'b0;
      r_dbg_pend <= 1'b0;
      r_dbg_rsv  <= 1'b0;
    end else begin
      r_cpu_pend <= w_cpu_rd;
      r_cpu_rsv  <= (cpu_addr > C_LAST_ADDR);
      r_dbg_pend <= w_dbg_rd;
      r_dbg_rsv  <= (dbg_addr > C_LAST_ADDR);
    end
  end

  // Read data is passed through from the register file only in the response cycle.
  assign cpu_rvalid = r_cpu_pend;
  assign cpu_rdata  = (r_cpu_pend && !r_cpu_rsv) ? rf_rdata : 8'h00;
  assign dbg_rvalid = r_dbg_pend;
  assign dbg_rdata  = (r_dbg_pend && !r_dbg_rsv) ? rf_rdata : 8'h00;

  // Halt handshake FSM; stall/halted are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_RUN;
      r_cpu_stall  <= 1'b0;
      r_dbg_halted <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (dbg_halt_req) begin
            r_state     <= S_DRAIN;
            r_cpu_stall <= 1'b1;
          end
        end
        S_DRAIN: begin
          // Halt withdrawal wins over completing the drain.
          if (!dbg_halt_req) begin
            r_state     <= S_RUN;
            r_cpu_stall <= 1'b0;
          end else if (cpu_idle && !r_cpu_pend && !w_cpu_rd) begin
            r_state      <= S_HALTED;
            r_dbg_halted <= 1'b1;
          end
        end
        S_HALTED: begin
          if (!dbg_halt_req) begin
            r_state      <= S_RUN;
            r_cpu_stall  <= 1'b0;
            r_dbg_halted <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_RUN;
          r_cpu_stall  <= 1'b0;
          r_dbg_halted <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_stall  = r_cpu_stall;
  assign dbg_halted = r_dbg_halted;

endmodule

`default_nettype wire

// File: tb/tb_reg_port_arbiter.sv
// ============================================================================
// Module  : tb_reg_port_arbiter
// Brief   : Self-checking bench for reg_port_arbiter: vector table, directed
//           multi-cycle sequences and random traffic against a reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_reg_port_arbiter;

  localparam int STARVE_LIMIT = 4;
`ifdef STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_req, cpu_we, dbg_req, dbg_we, dbg_halt_req, cpu_idle;
  logic [3:0] cpu_addr, dbg_addr;
  logic [7:0] cpu_wdata, dbg_wdata;
  logic       cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, cpu_stall, dbg_halted;
  logic [7:0] cpu_rdata, dbg_rdata;
  logic       rf_en, rf_we;
  logic [3:0] rf_addr;
  logic [7:0] rf_wdata, rf_rdata;

  reg_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_halt_req(dbg_halt_req), .cpu_idle(cpu_idle),
    .cpu_stall(cpu_stall), .dbg_halted(dbg_halted),
    .rf_en(rf_en), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata)
  );

  always #5 clk = ~clk;

  // Register file stub: data one cycle after a read strobe, garbage otherwise.
  logic [7:0] bmem [16];
  always @(posedge clk) begin
    if (rf_en && !rf_we) rf_rdata <= bmem[rf_addr];
    else                 rf_rdata <= 8'($urandom);
    if (rf_en && rf_we)  bmem[rf_addr] <= rf_wdata;
  end

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: 0 RUN, 1 DRAIN, 2 HALTED.
  int         m_st;
  int         m_cnt;
  bit         m_cpu_v, m_dbg_v;
  logic [7:0] m_cpu_d, m_dbg_d;
  logic [7:0] m_rf [16];

  // Snapshot of DUT outputs at the last check point.
  // [35]cpu_gnt [34]dbg_gnt [33]rf_en [32]rf_we [31:28]rf_addr [27:20]rf_wdata
  // [19]cpu_rvalid [18:11]cpu_rdata [10]dbg_rvalid [9:2]dbg_rdata [1]stall [0]halted
  logic [35:0] g_act;

  function automatic logic [35:0] pk(bit cg, bit dg, bit en, bit we, logic [3:0] a,
                                     logic [7:0] wd, bit cv, logic [7:0] cd,
                                     bit dv, logic [7:0] dd, bit st, bit hl);
    return {cg, dg, en, we, a, wd, cv, cd, dv, dd, st, hl};
  endfunction

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_cpu_v = 0; m_dbg_v = 0; m_cpu_d = 8'h00; m_dbg_d = 8'h00;
  endtask

  // One clock cycle: check outputs at mid-cycle against the model, advance model.
  task automatic tick(input string tag);
    logic [35:0] exp;
    bit          halted, force_dbg, win_cpu, win_dbg, rsv, en, we;
    logic [3:0]  a;
    logic [7:0]  wd;
    int          nst;
    #4;
    halted = (m_st == 2);
    force_dbg = GUARD && !halted && dbg_req && (m_cnt == STARVE_LIMIT);
    win_cpu = 1'b0;
    win_dbg = 1'b0;
    if (halted)         win_dbg = dbg_req;
    else if (force_dbg) win_dbg = 1'b1;
    else if (cpu_req)   win_cpu = 1'b1;
    else                win_dbg = dbg_req;
    a   = win_dbg ? dbg_addr  : cpu_addr;
    wd  = win_dbg ? dbg_wdata : cpu_wdata;
    we  = win_dbg ? dbg_we    : cpu_we;
    rsv = (a >= 4'd9);
    en  = (win_cpu || win_dbg) && !rsv;
    if (!rst_n) exp = '0;
    else exp = pk(win_cpu, win_dbg, en, en && we, en ? a : 4'h0, en ? wd : 8'h00,
                  m_cpu_v, m_cpu_v ? m_cpu_d : 8'h00, m_dbg_v, m_dbg_v ? m_dbg_d : 8'h00,
                  m_st != 0, m_st == 2);
    g_act = {cpu_gnt, dbg_gnt, rf_en, rf_we, rf_addr, rf_wdata, cpu_rvalid, cpu_rdata,
             dbg_rvalid, dbg_rdata, cpu_stall, dbg_halted};
    chk(tag, g_act, exp);
    if (!rst_n) begin
      model_reset();
    end else begin
      nst = m_st;
      if (m_st == 0 && dbg_halt_req) nst = 1;
      else if (m_st == 1 && !dbg_halt_req) nst = 0;
      else if (m_st == 1 && cpu_idle && !m_cpu_v && !(win_cpu && !cpu_we)) nst = 2;
      else if (m_st == 2 && !dbg_halt_req) nst = 0;
      if (win_dbg || !dbg_req) m_cnt = 0;
      else if (m_cnt < STARVE_LIMIT) m_cnt = m_cnt + 1;
      m_cpu_v = win_cpu && !cpu_we;
      m_dbg_v = win_dbg && !dbg_we;
      m_cpu_d = rsv ? 8'h00 : m_rf[a];
      m_dbg_d = rsv ? 8'h00 : m_rf[a];
      if (en && we) m_rf[a] = wd;
      m_st = nst;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  typedef struct {
    logic        cr, cw;
    logic [3:0]  ca;
    logic [7:0]  cd;
    logic        dr, dw;
    logic [3:0]  da;
    logic [7:0]  dd;
    logic [35:0] exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    for (int i = 0; i < 16; i++) begin bmem[i] = 8'h00; m_rf[i] = 8'h00; end
    model_reset();
    rst_n = 1'b0; dbg_halt_req = 0; cpu_idle = 1; idle_inputs();

    //         cpu r  w  a     wd      dbg r  w  a     wd     expected
    tbl[0]  = '{0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, pk(0,0,0,0,4'd0,8'h00,0,8'h00,0,8'h00,0,0)};
    tbl[1]  = '{1, 1, 4'd3, 8'h5A, 0, 0, 4'd0, 8'h00, pk(1,0,1,1,4'd3,8'h5A,0,8'h00,0,8'h00,0,0)};
    tbl[2]  = '{1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00, pk(1,0,1,0,4'd3,8'h00,0,8'h00,0,8'h00,0,0)};
    tbl[3]  = '{0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, pk(0,0,0,0,4'd0,8'h00,1,8'h5A,0,8'h00,0,0)};
    tbl[4]  = '{1, 1, 4'd8, 8'h11, 1, 0, 4'd3, 8'h00, pk(1,0,1,1,4'd8,8'h11,0,8'h00,0,8'h00,0,0)};
    tbl[5]  = '{0, 0, 4'd0, 8'h00, 1, 0, 4'd3, 8'h00, pk(0,1,1,0,4'd3,8'h00,0,8'h00,0,8'h00,0,0)};
    tbl[6]  = '{0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, pk(0,0,0,0,4'd0,8'h00,0,8'h00,1,8'h5A,0,0)};
    tbl[7]  = '{0, 0, 4'd0, 8'h00, 1, 1, 4'd12, 8'hFF, pk(0,1,0,0,4'd0,8'h00,0,8'h00,0,8'h00,0,0)};
    tbl[8]  = '{0, 0, 4'd0, 8'h00, 1, 0, 4'd12, 8'h00, pk(0,1,0,0,4'd0,8'h00,0,8'h00,0,8'h00,0,0)};
    tbl[9]  = '{0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, pk(0,0,0,0,4'd0,8'h00,0,8'h00,1,8'h00,0,0)};
    tbl[10] = '{1, 0, 4'd8, 8'h00, 0, 0, 4'd0, 8'h00, pk(1,0,1,0,4'd8,8'h00,0,8'h00,0,8'h00,0,0)};
    tbl[11] = '{0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, pk(0,0,0,0,4'd0,8'h00,1,8'h11,0,8'h00,0,0)};

    // Reset state, with requests active to show grants are masked.
    repeat (2) @(posedge clk);
    #1;
    cpu_req = 1; dbg_req = 1;
    tick("reset_hold");
    chk("reset_outputs_zero", g_act, 36'h0);
    idle_inputs();
    rst_n = 1'b1;
    tick("reset_release");

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cd;
      dbg_req = tbl[i].dr; dbg_we = tbl[i].dw; dbg_addr = tbl[i].da; dbg_wdata = tbl[i].dd;
      tick($sformatf("tbl_model_%0d", i));
      chk($sformatf("tbl_row_%0d", i), g_act, tbl[i].exp);
    end
    idle_inputs();
    tick("gap0");

    // Starvation: cpu holds its request, debug reads sp from cycle 0.
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd0;
    dbg_req = 1; dbg_we = 0; dbg_addr = 4'd8;
    for (int k = 0; k < 7; k++) begin
      tick($sformatf("starve_model_%0d", k));
      chk($sformatf("starve_dbg_gnt_c%0d", k), {35'd0, g_act[34]}, {35'd0, GUARD && (k == 4)});
      chk($sformatf("starve_cpu_gnt_c%0d", k), {35'd0, g_act[35]}, {35'd0, !(GUARD && (k == 4))});
      if (g_act[34]) dbg_req = 0;
    end
    idle_inputs();
    tick("gap1");

    // Halt handshake: idle rises after three busy cycles.
    dbg_halt_req = 1; cpu_idle = 0;
    tick("halt_c0");
    chk("halt_c0_stall", {34'd0, g_act[1:0]}, 36'd0);
    for (int k = 1; k < 3; k++) begin
      tick($sformatf("halt_c%0d", k));
      chk($sformatf("halt_c%0d_stall", k), {34'd0, g_act[1:0]}, 36'd2);
    end
    cpu_idle = 1;
    tick("halt_c3");
    chk("halt_c3_stall", {34'd0, g_act[1:0]}, 36'd2);
    // Halted: cpu keeps asking, debug writes then reads a reserved address.
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd1;
    dbg_req = 1; dbg_we = 1; dbg_addr = 4'd12; dbg_wdata = 8'hFF;
    tick("halted_wr");
    chk("halted_wr_gnt_en_st", {32'd0, g_act[35:33], g_act[0]}, 36'b0101);
    dbg_we = 0; dbg_wdata = 8'h00;
    tick("halted_rd");
    chk("halted_rd_gnt_en", {33'd0, g_act[35:33]}, 36'b010);
    dbg_req = 0;
    tick("halted_resp");
    chk("halted_dbg_resp", {26'd0, g_act[35], g_act[10:2]}, {26'd0, 1'b0, 1'b1, 8'h00});
    dbg_halt_req = 0;
    tick("unhalt_c0");
    chk("unhalt_c0_cpu_gnt", {35'd0, g_act[35]}, 36'd0);
    tick("unhalt_c1");
    chk("unhalt_c1_run", {33'd0, g_act[35], g_act[1:0]}, 36'b100);
    idle_inputs();
    tick("gap2");

    // Reset in the cycle after a granted cpu read of r0, while draining.
    dbg_halt_req = 1; cpu_idle = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd0;
    tick("rstmid_read");
    idle_inputs();
    dbg_halt_req = 0;
    rst_n = 1'b0;
    tick("rstmid_hold");
    chk("rstmid_outputs_zero", g_act, 36'h0);
    tick("rstmid_hold2");
    rst_n = 1'b1;
    tick("rstmid_release");
    chk("rstmid_no_rvalid_run", {33'd0, g_act[19], g_act[1:0]}, 36'd0);

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      cpu_req   = 1'($urandom_range(0, 1));
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 4'($urandom);
      cpu_wdata = 8'($urandom);
      dbg_req   = 1'($urandom_range(0, 1));
      dbg_we    = 1'($urandom_range(0, 1));
      dbg_addr  = 4'($urandom);
      dbg_wdata = 8'($urandom);
      cpu_idle  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 11) == 0) dbg_halt_req = !dbg_halt_req;
      rst_n = ($urandom_range(0, 99) != 0);
      tick("random");
    end
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
